// File: rtl/mmu_tile_sched_if.sv
// Handshake bundle between the tile scheduler and its host / mmu side.
// master drives start/abort/data_ready; slave is the scheduler.
interface mmu_tile_sched_if #(
  parameter int IW = 1
);
  logic          start;
  logic          abort;
  logic          mmu_data_ready;
  logic          mmu_enable;
  logic [IW-1:0] tile_i;
  logic [IW-1:0] tile_j;
  logic [IW-1:0] tile_k;
  logic          accum_sel;
  logic          out_wr;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output start, abort, mmu_data_ready,
    input  mmu_enable, tile_i, tile_j, tile_k,
    input  accum_sel, out_wr, busy, done, err
  );

  modport slave (
    input  start, abort, mmu_data_ready,
    output mmu_enable, tile_i, tile_j, tile_k,
    output accum_sel, out_wr, busy, done, err
  );
endinterface

// File: rtl/mmu_tile_sched.sv
// Tiled C = A*B + bias sequencer for one mmu_short instance.
// Walks k innermost, then j, then i; one RUN+GAP per pass.
module mmu_tile_sched #(
  parameter int M_TILES = 2,
  parameter int N_TILES = 2,
  parameter int K_TILES = 2,
  parameter int TIMEOUT = 15
) (
  input logic         clk,
  input logic         rst_n,
  mmu_tile_sched_if.slave io
);
  localparam int MX0 =
    (M_TILES > N_TILES) ? M_TILES : N_TILES;
  localparam int MX1 =
    (MX0 > K_TILES) ? MX0 : K_TILES;
  localparam int MX = (MX1 > 2) ? MX1 : 2;
  localparam int IW = $clog2(MX);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [IW-1:0] IMAX = IW'(M_TILES - 1);
  localparam logic [IW-1:0] JMAX = IW'(N_TILES - 1);
  localparam logic [IW-1:0] KMAX = IW'(K_TILES - 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE, RUN, GAP, DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] ci;
  logic [IW-1:0] cj;
  logic [IW-1:0] ck;
  logic [TW-1:0] tcnt;
  logic          en_q;
  logic          wr_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic last_i;
  logic last_j;
  logic last_k;

  assign last_i = (ci == IMAX);
  assign last_j = (cj == JMAX);
  assign last_k = (ck == KMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ci     <= '0;
      cj     <= '0;
      ck     <= '0;
      tcnt   <= '0;
      en_q   <= 1'b0;
      wr_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      if (io.abort) begin
        state  <= IDLE;
        en_q   <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (io.start) begin
              state  <= RUN;
              ci     <= '0;
              cj     <= '0;
              ck     <= '0;
              tcnt   <= '0;
              err_q  <= 1'b0;
              en_q   <= 1'b1;
              busy_q <= 1'b1;
            end
          end
          RUN: begin
            if (io.mmu_data_ready) begin
              state <= GAP;
              en_q  <= 1'b0;
              wr_q  <= last_k;
            end else if (tcnt == TLIM) begin
              state  <= IDLE;
              err_q  <= 1'b1;
              en_q   <= 1'b0;
              busy_q <= 1'b0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          GAP: begin
            if (last_i && last_j && last_k) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state <= RUN;
              en_q  <= 1'b1;
              tcnt  <= '0;
              // k innermost, then j, then i
              if (!last_k) begin
                ck <= ck + 1'b1;
              end else if (!last_j) begin
                ck <= '0;
                cj <= cj + 1'b1;
              end else begin
                ck <= '0;
                cj <= '0;
                ci <= ci + 1'b1;
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign io.mmu_enable = en_q;
  assign io.tile_i     = ci;
  assign io.tile_j     = cj;
  assign io.tile_k     = ck;
  assign io.accum_sel  = (ck != '0);
  assign io.out_wr     = wr_q & ~io.abort;
  assign io.done       = done_q & ~io.abort;
  assign io.busy       = busy_q;
  assign io.err        = err_q;
endmodule

// File: tb/tb_mmu_tile_sched.sv
// Directed bench: 2x2x2 scheduler with an mmu latency model,
// plus a 1x1x1 instance driving a 2x2 integer matmul model.
module tb_mmu_tile_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy_off = 1'b0;
  int   cyc = 0;
  int   npass = 0;
  int   ntot = 0;
  int   nfail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mmu_tile_sched_if #(.IW(1)) io ();
  mmu_tile_sched_if #(.IW(1)) io1 ();

  mmu_tile_sched #(
    .M_TILES(2), .N_TILES(2),
    .K_TILES(2), .TIMEOUT(15)
  ) dut (.clk(clk), .rst_n(rst_n), .io(io));

  mmu_tile_sched #(
    .M_TILES(1), .N_TILES(1),
    .K_TILES(1), .TIMEOUT(15)
  ) dut1 (.clk(clk), .rst_n(rst_n), .io(io1));

  // mmu latency model: data_ready in 3rd enable cycle
  logic [3:0] ec;
  logic [3:0] ec1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ec  <= '0;
      ec1 <= '0;
    end else begin
      ec  <= io.mmu_enable ? ec + 4'd1 : 4'd0;
      ec1 <= io1.mmu_enable ? ec1 + 4'd1 : 4'd0;
    end
  end
  assign io.mmu_data_ready =
    io.mmu_enable && (ec == 4'd2) && !rdy_off;
  assign io1.mmu_data_ready =
    io1.mmu_enable && (ec1 == 4'd2);

  // 2x2 integer matmul for the single-tile instance
  int ma [2][2] = '{'{1, 2}, '{3, 4}};
  int mb [2][2] = '{'{5, 6}, '{7, 8}};
  int mbias [2][2] = '{'{1, 1}, '{1, 1}};
  int mo [2][2];
  always @(posedge clk) begin
    if (io1.mmu_data_ready) begin
      for (int r = 0; r < 2; r++) begin
        for (int q = 0; q < 2; q++) begin
          mo[r][q] <= (io1.accum_sel ? mo[r][q]
                       : mbias[r][q])
                    + ma[r][0] * mb[0][q]
                    + ma[r][1] * mb[1][q];
        end
      end
    end
  end

  // monitors
  logic [1:0] wr_q [$];
  logic [3:0] pass_q [$];
  int         gap_q [$];
  int         low = 0;
  int         done_n = 0;
  int         done_cyc = 0;
  int         unstable = 0;
  int         both_bad = 0;
  logic       prev_en = 1'b0;
  logic [2:0] cur_ijk = '0;
  int         wr1_n = 0;
  int         done1_n = 0;
  int         done1_cyc = 0;
  int         cap [2][2];

  always @(negedge clk) begin
    if (io.out_wr) begin
      wr_q.push_back({io.tile_i, io.tile_j});
      if (io.done) both_bad++;
    end
    if (io.done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (io.mmu_enable && !prev_en) begin
      pass_q.push_back({io.tile_i, io.tile_j,
                        io.tile_k, io.accum_sel});
      cur_ijk = {io.tile_i, io.tile_j, io.tile_k};
    end
    if (io.busy && !io.mmu_enable &&
        cur_ijk != {io.tile_i, io.tile_j, io.tile_k})
      unstable++;
    if (io.mmu_enable && prev_en &&
        cur_ijk != {io.tile_i, io.tile_j, io.tile_k})
      unstable++;
    if (io.busy && !io.mmu_enable) begin
      low++;
    end else if (io.mmu_enable && low != 0) begin
      gap_q.push_back(low);
      low = 0;
    end
    prev_en = io.mmu_enable;
    if (io1.out_wr) begin
      wr1_n++;
      cap = mo;
    end
    if (io1.done) begin
      done1_n++;
      done1_cyc = cyc;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clr();
    wr_q.delete();
    pass_q.delete();
    gap_q.delete();
    low = 0;
    done_n = 0;
    done_cyc = 0;
    unstable = 0;
    both_bad = 0;
  endtask

  task automatic go(output int c);
    io.start = 1'b1;
    c = cyc;
    tick(1);
    io.start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    for (int t = 0; t < lim; t++) begin
      if (done_n != 0) break;
      tick(1);
    end
  endtask

  int c0;
  logic [3:0] ep;

  initial begin
    io.start = 1'b0;
    io.abort = 1'b0;
    io1.start = 1'b0;
    io1.abort = 1'b0;
    tick(2);
    chk("reset_outs",
        {io.mmu_enable, io.busy, io.done, io.err,
         io.out_wr, io.tile_i, io.tile_j, io.tile_k,
         io.accum_sel}, 0);
    rst_n = 1'b1;
    tick(2);

    // full 2x2x2 product
    clr();
    go(c0);
    wait_done(60);
    chk("done_cnt", done_n, 1);
    chk("done_cyc", done_cyc, c0 + 33);
    chk("wr_cnt", wr_q.size(), 4);
    if (wr_q.size() == 4) begin
      chk("wr_order",
          {wr_q[0], wr_q[1], wr_q[2], wr_q[3]},
          8'b00_01_10_11);
    end
    chk("pass_cnt", pass_q.size(), 8);
    for (int p = 0; p < 8 && p < pass_q.size(); p++) begin
      ep = {p[2], p[1], p[0], p[0]};
      chk($sformatf("pass%0d", p), pass_q[p], ep);
    end
    chk("gap_cnt", gap_q.size(), 7);
    foreach (gap_q[g])
      chk($sformatf("gap%0d", g), gap_q[g], 1);
    chk("stable", unstable, 0);
    chk("wr_done_excl", both_bad, 0);
    tick(1);
    chk("idle_after", {io.busy, io.done, io.mmu_enable}, 0);

    // timeout with no data_ready
    clr();
    rdy_off = 1'b1;
    go(c0);
    tick(14);
    chk("to_run15", {io.busy, io.err, io.mmu_enable},
        3'b101);
    tick(1);
    chk("to_err", {io.busy, io.err, io.mmu_enable},
        3'b010);
    tick(5);
    chk("to_nodone", done_n, 0);
    rdy_off = 1'b0;
    clr();
    go(c0);
    chk("err_clr", {io.err, io.mmu_enable}, 2'b01);

    // abort in 5th pass (i=1,j=0,k=0)
    tick(16);
    chk("ab_pass5",
        {io.mmu_enable, io.tile_i, io.tile_j, io.tile_k},
        4'b1100);
    io.abort = 1'b1;
    tick(1);
    io.abort = 1'b0;
    chk("ab_off", {io.mmu_enable, io.busy}, 0);
    chk("ab_wr_before", wr_q.size(), 2);
    tick(40);
    chk("ab_wr_after", wr_q.size(), 2);
    chk("ab_nodone", done_n, 0);
    chk("ab_hold", {io.tile_i, io.tile_j, io.tile_k},
        3'b100);
    clr();
    go(c0);
    chk("ab_restart",
        {io.mmu_enable, io.tile_i, io.tile_j, io.tile_k},
        4'b1000);
    wait_done(60);
    chk("ab_redone", done_cyc, c0 + 33);

    // async reset mid-run
    tick(2);
    clr();
    go(c0);
    tick(6);
    rst_n = 1'b0;
    #1;
    chk("rst_async",
        {io.mmu_enable, io.busy, io.done, io.err,
         io.out_wr, io.tile_i, io.tile_j, io.tile_k,
         io.accum_sel}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("rst_idle", {io.busy, io.mmu_enable}, 0);

    // start pulses while busy are ignored
    clr();
    go(c0);
    tick(2);
    io.start = 1'b1;
    tick(1);
    io.start = 1'b0;
    tick(6);
    io.start = 1'b1;
    tick(1);
    io.start = 1'b0;
    wait_done(60);
    chk("busy_start_done", done_cyc, c0 + 33);
    chk("busy_start_wr", wr_q.size(), 4);

    // single-tile instance with matmul model
    tick(3);
    io1.start = 1'b1;
    c0 = cyc;
    tick(1);
    io1.start = 1'b0;
    tick(8);
    chk("t1_wr", wr1_n, 1);
    chk("t1_done", done1_n, 1);
    chk("t1_done_cyc", done1_cyc, c0 + 5);
    chk("t1_c00", cap[0][0], 20);
    chk("t1_c01", cap[0][1], 23);
    chk("t1_c10", cap[1][0], 44);
    chk("t1_c11", cap[1][1], 51);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
